// File: rtl/vpu_seq_pkg.sv
// Shared types and constants for the vector beat sequencer.
// Optional perf counter elsewhere is gated by VPU_SEQ_PERF_EN.
package vpu_seq_pkg;

    localparam int VPU_LANES = 8;
    localparam int LANE_W    = 16;
    localparam int BEATS     = 4;
    localparam int VEC_W     = VPU_LANES * LANE_W;
    localparam int SEL_W     = 19;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_MUL = 5'd2,
        OP_ITF = 5'd3,
        OP_FTI = 5'd4,
        OP_MAX = 5'd5,
        OP_MIN = 5'd6,
        OP_AND = 5'd7,
        OP_OR  = 5'd8,
        OP_XOR = 5'd9,
        OP_SRA = 5'd10,
        OP_SRL = 5'd11,
        OP_SLL = 5'd12,
        OP_CGE = 5'd13,
        OP_CLT = 5'd14,
        OP_CEQ = 5'd15,
        OP_CNQ = 5'd16
    } vpu_op_e;

    // Bit 0 picks float lanes; op selects follow in enum order.
    localparam int SEL_IF    = 0;
    localparam int SEL_ADD   = 1;
    localparam int SEL_SUB   = 2;
    localparam int SEL_MUL   = 3;
    localparam int SEL_ITF   = 4;
    localparam int SEL_FTI   = 5;
    localparam int SEL_MAX   = 6;
    localparam int SEL_MIN   = 7;
    localparam int SEL_AND   = 8;
    localparam int SEL_OR    = 9;
    localparam int SEL_XOR   = 10;
    localparam int SEL_SRA   = 11;
    localparam int SEL_SRL   = 12;
    localparam int SEL_SLL   = 13;
    localparam int SEL_CGE   = 14;
    localparam int SEL_CLT   = 15;
    localparam int SEL_CEQ   = 16;
    localparam int SEL_CNQ   = 17;
    localparam int SEL_SPARE = 18;

    typedef logic [1:0] fsm_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_EX   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/vpu_op_decode.sv
// Combinational op decode: one-hot VPU select bus plus compare/valid flags.
// Part of vpu_beat_seq (VPU_SEQ_PERF_EN does not affect this file).
module vpu_op_decode
    import vpu_seq_pkg::*;
(
    input  logic [4:0]       op,
    input  logic             fp,
    output logic [SEL_W-1:0] sel,
    output logic             is_cmp,
    output logic             is_valid
);

    logic [4:0] idx;

    always_comb begin
        sel      = '0;
        is_cmp   = 1'b0;
        idx      = op + 5'd1;
        is_valid = (op <= OP_CNQ);
        if (is_valid) begin
            sel[SEL_IF] = fp;
            sel[idx]    = 1'b1;
            is_cmp      = op inside {OP_CGE, OP_CLT, OP_CEQ, OP_CNQ};
        end
    end

endmodule

// File: rtl/vpu_beat_seq.sv
// Beat sequencer: runs one vector op as up to 4 beats of 8 lanes.
// Define VPU_SEQ_PERF_EN to add the busy_cycles counter port.
module vpu_beat_seq
    import vpu_seq_pkg::*;
#(
    parameter  int VREGS = 32,
    parameter  int MAXVL = 32,
    localparam int RW    = $clog2(VREGS),
    localparam int AW    = RW + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4:0]           req_op,
    input  logic                 req_fp,
    input  logic [RW-1:0]        req_vs1,
    input  logic [RW-1:0]        req_vs2,
    input  logic [RW-1:0]        req_vd,
    input  logic [5:0]           req_vl,
    input  logic [31:0]          req_mask,
    output logic [AW-1:0]        vrf_raddr,
    output logic [AW-1:0]        vrf_raddr2,
    input  logic [VEC_W-1:0]     vrf_rdata1,
    input  logic [VEC_W-1:0]     vrf_rdata2,
    output logic [SEL_W-1:0]     vpu_sel,
    output logic [VEC_W-1:0]     vpu_vs1,
    output logic [VEC_W-1:0]     vpu_vs2,
    output logic [VPU_LANES-1:0] vpu_mask,
    input  logic [VEC_W-1:0]     vpu_vd,
    input  logic [VPU_LANES-1:0] vpu_rd,
    output logic                 vrf_we,
    output logic [AW-1:0]        vrf_waddr,
    output logic [VEC_W-1:0]     vrf_wdata,
    output logic [VPU_LANES-1:0] vrf_wlane,
    output logic                 resp_valid,
    input  logic                 resp_ready,
`ifdef VPU_SEQ_PERF_EN
    output logic [31:0]          busy_cycles,
`endif
    output logic [31:0]          resp_rd
);

    fsm_state_t          state;
    logic [1:0]          beat;
    logic [1:0]          last_beat;
    logic [4:0]          op_q;
    logic                fp_q;
    logic [RW-1:0]       vs1_q;
    logic [RW-1:0]       vs2_q;
    logic [RW-1:0]       vd_q;
    logic [5:0]          vl_q;
    logic [31:0]         mask_q;

    logic [5:0]          vl_c;
    logic [1:0]          nb_m1;
    logic [4:0]          dec_op;
    logic                dec_fp;
    logic [SEL_W-1:0]    dec_sel;
    logic                dec_cmp;
    logic                dec_valid;
    logic [VPU_LANES-1:0] lane_en;
    logic                rd_st;
    logic                ex_st;

    assign rd_st = (state == ST_RD);
    assign ex_st = (state == ST_EX);

    assign vl_c  = (req_vl > 6'(MAXVL)) ? 6'(MAXVL) : req_vl;
    assign nb_m1 = 2'((vl_c - 6'd1) >> 3);

    // Decode the incoming op while idle so a bad opcode can skip the beats.
    assign dec_op = (state == ST_IDLE) ? req_op : op_q;
    assign dec_fp = (state == ST_IDLE) ? req_fp : fp_q;

    vpu_op_decode u_dec (
        .op       (dec_op),
        .fp       (dec_fp),
        .sel      (dec_sel),
        .is_cmp   (dec_cmp),
        .is_valid (dec_valid)
    );

    always_comb begin
        lane_en = '0;
        for (int i = 0; i < VPU_LANES; i++) begin
            lane_en[i] = mask_q[{beat, 3'(i)}]
                       & ({1'b0, beat, 3'(i)} < vl_q);
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);

    assign vrf_raddr  = rd_st ? {vs1_q, beat} : '0;
    assign vrf_raddr2 = rd_st ? {vs2_q, beat} : '0;

    assign vpu_sel    = ex_st ? dec_sel : '0;
    assign vpu_mask   = ex_st ? lane_en : '0;

    assign vrf_we     = ex_st & ~dec_cmp;
    assign vrf_waddr  = vrf_we ? {vd_q, beat} : '0;
    assign vrf_wdata  = vrf_we ? vpu_vd : '0;
    assign vrf_wlane  = vrf_we ? lane_en : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            beat      <= '0;
            last_beat <= '0;
            op_q      <= '0;
            fp_q      <= 1'b0;
            vs1_q     <= '0;
            vs2_q     <= '0;
            vd_q      <= '0;
            vl_q      <= '0;
            mask_q    <= '0;
            vpu_vs1   <= '0;
            vpu_vs2   <= '0;
            resp_rd   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        fp_q      <= req_fp;
                        vs1_q     <= req_vs1;
                        vs2_q     <= req_vs2;
                        vd_q      <= req_vd;
                        vl_q      <= vl_c;
                        mask_q    <= req_mask;
                        beat      <= '0;
                        last_beat <= nb_m1;
                        resp_rd   <= '0;
                        if (vl_c == 6'd0 || !dec_valid) state <= ST_RESP;
                        else                            state <= ST_RD;
                    end
                end
                ST_RD: begin
                    vpu_vs1 <= vrf_rdata1;
                    vpu_vs2 <= vrf_rdata2;
                    state   <= ST_EX;
                end
                ST_EX: begin
                    if (dec_cmp)
                        resp_rd[{beat, 3'b000} +: 8] <= vpu_rd & lane_en;
                    if (beat == last_beat) begin
                        state <= ST_RESP;
                    end else begin
                        beat  <= beat + 2'd1;
                        state <= ST_RD;
                    end
                end
                default: begin
                    if (resp_ready) state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef VPU_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_cycles <= '0;
        else if (state != ST_IDLE && busy_cycles != 32'hFFFF_FFFF)
            busy_cycles <= busy_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_vpu_beat_seq.sv
// Directed bench for vpu_beat_seq with a behavioural VRF and VPU.
// Build with VPU_SEQ_PERF_EN to also check busy_cycles.
module tb_vpu_beat_seq;
    import vpu_seq_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [4:0]   req_op = '0;
    logic         req_fp = 1'b0;
    logic [4:0]   req_vs1 = '0;
    logic [4:0]   req_vs2 = '0;
    logic [4:0]   req_vd = '0;
    logic [5:0]   req_vl = '0;
    logic [31:0]  req_mask = '0;
    logic [6:0]   vrf_raddr;
    logic [6:0]   vrf_raddr2;
    logic [127:0] vrf_rdata1;
    logic [127:0] vrf_rdata2;
    logic [18:0]  vpu_sel;
    logic [127:0] vpu_vs1;
    logic [127:0] vpu_vs2;
    logic [7:0]   vpu_mask;
    logic [127:0] vpu_vd;
    logic [7:0]   vpu_rd;
    logic         vrf_we;
    logic [6:0]   vrf_waddr;
    logic [127:0] vrf_wdata;
    logic [7:0]   vrf_wlane;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [31:0]  resp_rd;
`ifdef VPU_SEQ_PERF_EN
    logic [31:0]  busy_cycles;
`endif

    vpu_beat_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_fp     (req_fp),
        .req_vs1    (req_vs1),
        .req_vs2    (req_vs2),
        .req_vd     (req_vd),
        .req_vl     (req_vl),
        .req_mask   (req_mask),
        .vrf_raddr  (vrf_raddr),
        .vrf_raddr2 (vrf_raddr2),
        .vrf_rdata1 (vrf_rdata1),
        .vrf_rdata2 (vrf_rdata2),
        .vpu_sel    (vpu_sel),
        .vpu_vs1    (vpu_vs1),
        .vpu_vs2    (vpu_vs2),
        .vpu_mask   (vpu_mask),
        .vpu_vd     (vpu_vd),
        .vpu_rd     (vpu_rd),
        .vrf_we     (vrf_we),
        .vrf_waddr  (vrf_waddr),
        .vrf_wdata  (vrf_wdata),
        .vrf_wlane  (vrf_wlane),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
`ifdef VPU_SEQ_PERF_EN
        .busy_cycles(busy_cycles),
`endif
        .resp_rd    (resp_rd)
    );

    always #5 clk = ~clk;

    // VRF: read data settles from the address within the RD cycle.
    logic [127:0] mem [0:127];
    assign vrf_rdata1 = mem[vrf_raddr];
    assign vrf_rdata2 = mem[vrf_raddr2];

    // VPU: lane add (sub when selected), equality as compare bit.
    always_comb begin
        logic [15:0] a;
        logic [15:0] b;
        a = '0;
        b = '0;
        vpu_vd = '0;
        vpu_rd = '0;
        for (int i = 0; i < 8; i++) begin
            a = vpu_vs1[16*i +: 16];
            b = vpu_vs2[16*i +: 16];
            vpu_vd[16*i +: 16] = vpu_sel[SEL_SUB] ? a - b : a + b;
            vpu_rd[i] = (a == b);
        end
    end

    typedef struct {
        logic [4:0]  op;
        logic        fp;
        logic [5:0]  vl;
        logic [31:0] mask;
        int          k1;
        int          k2;
        int          cyc;
        int          nwr;
        logic [31:0] rd;
        logic [7:0]  lastw;
    } vec_t;

    vec_t tv [9];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_wr;
    int   n_sel;
    int   sel_bad;
    logic [7:0] last_wlane;
    logic cur_fp;

    function automatic vec_t mk(logic [4:0] op, logic fp, logic [5:0] vl,
                                logic [31:0] mask, int k1, int k2, int cyc,
                                int nwr, logic [31:0] rd, logic [7:0] lastw);
        vec_t v;
        v.op = op; v.fp = fp; v.vl = vl; v.mask = mask;
        v.k1 = k1; v.k2 = k2; v.cyc = cyc; v.nwr = nwr;
        v.rd = rd; v.lastw = lastw;
        return v;
    endfunction

    function automatic logic [15:0] pat(int kind, int k);
        case (kind)
            0: return 16'(k);
            1: return 16'd1;
            2: return (k % 2 == 0) ? 16'(k) : 16'(k + 100);
            default: return 16'hDEAD;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_reg(input int r, input int kind);
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 8; i++)
                mem[r*4+b][16*i +: 16] = pat(kind, 8*b + i);
    endtask

    // Sample just after the falling edge, then advance one cycle.
    task automatic tick();
        #1;
        if (vrf_we) begin
            n_wr++;
            last_wlane = vrf_wlane;
            for (int i = 0; i < 8; i++)
                if (vrf_wlane[i])
                    mem[vrf_waddr][16*i +: 16] = vrf_wdata[16*i +: 16];
        end
        if (vpu_sel != '0) begin
            n_sel++;
            if (!$onehot(vpu_sel[18:1]) || vpu_sel[SEL_IF] !== cur_fp)
                sel_bad++;
        end
        @(negedge clk);
    endtask

    task automatic issue(input vec_t v);
        req_op = v.op; req_fp = v.fp; req_vl = v.vl; req_mask = v.mask;
        req_vs1 = 5'd1; req_vs2 = 5'd2; req_vd = 5'd3;
        req_valid = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int cyc;
        int vle;
        int errs;
        logic [15:0] e;
        logic [15:0] got;
`ifdef VPU_SEQ_PERF_EN
        logic [31:0] b0;
        b0 = busy_cycles;
`endif
        fill_reg(1, v.k1);
        fill_reg(2, v.k2);
        fill_reg(3, 99);
        n_wr = 0; n_sel = 0; sel_bad = 0; last_wlane = '0; cur_fp = v.fp;
        issue(v);
        check($sformatf("v%0d ready", id), 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check($sformatf("v%0d latency", id), cyc, v.cyc);
        check($sformatf("v%0d writes", id), n_wr, v.nwr);
        check($sformatf("v%0d resp_rd", id), resp_rd, v.rd);
        check($sformatf("v%0d last_wlane", id), 32'(last_wlane), 32'(v.lastw));
        check($sformatf("v%0d sel_beats", id), n_sel, (v.cyc - 1) / 2);
        check($sformatf("v%0d sel_onehot", id), sel_bad, 0);
        vle = (v.vl > 6'd32) ? 32 : int'(v.vl);
        errs = 0;
        for (int k = 0; k < 32; k++) begin
            if (v.nwr > 0 && k < vle && v.mask[k])
                e = (v.op == OP_SUB) ? pat(v.k1, k) - pat(v.k2, k)
                                     : pat(v.k1, k) + pat(v.k2, k);
            else
                e = 16'hDEAD;
            got = mem[12 + k/8][16*(k%8) +: 16];
            if (got !== e) errs++;
        end
        check($sformatf("v%0d vd_data", id), errs, 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check($sformatf("v%0d idle", id), 32'(req_ready), 32'd1);
`ifdef VPU_SEQ_PERF_EN
        check($sformatf("v%0d busy", id), busy_cycles - b0, 32'(v.cyc));
`endif
    endtask

    initial begin
        int cyc;
        vec_t h1;
        vec_t h2;
        for (int i = 0; i < 128; i++) mem[i] = '0;

        tv[0] = mk(OP_ADD, 0, 6'd32, 32'hFFFF_FFFF, 0, 1, 9, 4, 0, 8'hFF);
        tv[1] = mk(OP_ADD, 0, 6'd10, 32'hFFFF_FFFF, 0, 1, 5, 2, 0, 8'h03);
        tv[2] = mk(OP_CEQ, 0, 6'd32, 32'h0000_FFFF, 0, 2, 9, 0, 32'h5555, 0);
        tv[3] = mk(OP_ADD, 0, 6'd0,  32'hFFFF_FFFF, 0, 1, 1, 0, 0, 0);
        tv[4] = mk(OP_SUB, 0, 6'd40, 32'hF0F0_F0F0, 0, 1, 9, 4, 0, 8'hF0);
        tv[5] = mk(5'd20,  0, 6'd32, 32'hFFFF_FFFF, 0, 1, 1, 0, 0, 0);
        tv[6] = mk(OP_CEQ, 0, 6'd12, 32'hFFFF_FFFF, 0, 2, 5, 0, 32'h555, 0);
        tv[7] = mk(OP_ADD, 1, 6'd8,  32'hFFFF_FFFF, 0, 1, 3, 1, 0, 8'hFF);
        tv[8] = mk(OP_ADD, 0, 6'd17, 32'hFFFF_FFFF, 0, 1, 7, 3, 0, 8'h01);

        @(negedge clk);
        @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst vrf_we", 32'(vrf_we), 32'd0);
        check("rst vpu_sel", 32'(vpu_sel), 32'd0);
        check("rst vpu_mask", 32'(vpu_mask), 32'd0);
        check("rst resp_rd", resp_rd, 32'd0);
        check("rst raddr", 32'(vrf_raddr), 32'd0);
`ifdef VPU_SEQ_PERF_EN
        check("rst busy", busy_cycles, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(tv[i], i);

        // Response held off: outputs stay put, new request waits.
        h1 = mk(OP_CEQ, 0, 6'd8, 32'hFF, 0, 2, 3, 0, 32'h55, 0);
        h2 = mk(OP_ADD, 0, 6'd8, 32'hFF, 0, 1, 3, 1, 0, 8'hFF);
        fill_reg(1, 0);
        fill_reg(2, 2);
        issue(h1);
        tick();
        issue(h2);
        cyc = 1;
        while (!resp_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("hold latency", cyc, 3);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold%0d valid", c), 32'(resp_valid), 32'd1);
            check($sformatf("hold%0d rd", c), resp_rd, 32'h55);
            check($sformatf("hold%0d ready", c), 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("b2b ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("b2b accepted", 32'(req_ready), 32'd0);
        check("b2b resp_clr", 32'(resp_valid), 32'd0);
        cyc = 1;
        while (!resp_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("b2b latency", cyc, 3);
        check("b2b resp_rd", resp_rd, 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Reset asserted during beat 2 of a full-length op.
        fill_reg(1, 0);
        fill_reg(2, 1);
        n_wr = 0;
        cur_fp = 1'b0;
        issue(tv[0]);
        tick();
        req_valid = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        check("pre_rst vpu_mask", 32'(vpu_mask), 32'hFF);
        rst_n = 1'b0;
        #1;
        check("rst_mid vrf_we", 32'(vrf_we), 32'd0);
        check("rst_mid req_ready", 32'(req_ready), 32'd1);
        check("rst_mid vpu_vs1", vpu_vs1[31:0], 32'd0);
        check("rst_mid vpu_sel", 32'(vpu_sel), 32'd0);
`ifdef VPU_SEQ_PERF_EN
        check("rst_mid busy", busy_cycles, 32'd0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        check("rst_mid writes", n_wr, 2);
        check("rst_mid resp_valid", 32'(resp_valid), 32'd0);

        run_vec(tv[0], 99);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
